// File: rtl/mux2_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arb_pkg
// Purpose  : Shared definitions for the two-source round-robin arbiter:
//            state encoding, default burst limit, statistics counter width
//            and small grant-encoding helpers.
// Macros   : none (the MUX2_ARB_STATS_EN option lives in the top module)
// Revision : 1.0 - initial release
// ============================================================================
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_BURST = 4;
  localparam int STAT_W        = 16;

  // State that corresponds to owning the channel for source src.
  function automatic arb_state_t grant_state(input logic src);
    return src ? ST_GNT1 : ST_GNT0;
  endfunction

  // One-hot grant vector for source src.
  function automatic logic [1:0] grant_vec(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter_if
// Purpose  : Handshake/data bundle between the two sources, the arbiter and
//            the downstream consumer.
// Signals  : req[1:0], din0, din1   - source requests and data
//            rdy[1:0], gnt[1:0]     - per-source accept and grant
//            sel, dout, dout_valid  - muxed output channel
//            dout_ready             - downstream accept
// Modports : slave  - arbiter side
//            master - sources/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 1
);
  logic [1:0]        req;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic [1:0]        rdy;
  logic [1:0]        gnt;
  logic              sel;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport slave (
    input  req, din0, din1, dout_ready,
    output rdy, gnt, sel, dout, dout_valid
  );

  modport master (
    output req, din0, din1, dout_ready,
    input  rdy, gnt, sel, dout, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux2_rr_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module   : mux2to1_w
// Purpose  : DATA_W-wide combinational 2:1 multiplexer.
// Ports    : din0, din1 (in, DATA_W) - data inputs
//            sel        (in, 1)      - 0 selects din0, 1 selects din1
//            dout       (out, DATA_W)- selected data
// Revision : 1.0 - initial release
// ============================================================================
module mux2to1_w #(
  parameter int DATA_W = 1
) (
  input  wire logic [DATA_W-1:0] din0,
  input  wire logic [DATA_W-1:0] din1,
  input  wire logic              sel,
  output logic      [DATA_W-1:0] dout
);
  assign dout = sel ? din1 : din0;
endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Purpose  : Round-robin arbiter sharing one output channel between two
//            requesters, with a per-grant burst limit and the 2:1 data mux.
// Ports    : clk            (in)  rising-edge clock
//            rst_n          (in)  asynchronous active-low reset
//            bus            (mux2_rr_arbiter_if.slave) req/din0/din1/
//                           dout_ready in; rdy/gnt/sel/dout/dout_valid out
//            grant_cnt0/1   (out, 16) grant-event counters, only when
//                           MUX2_ARB_STATS_EN is defined
// Macros   : MUX2_ARB_STATS_EN - adds saturating grant statistics
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = 8
) (
  input wire logic clk,
  input wire logic rst_n,
  mux2_rr_arbiter_if.slave bus
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  arb_state_t        r_state;
  logic [1:0]        r_gnt;
  logic              r_sel;
  logic              r_pri;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_valid;
  logic              w_xfer;
  logic              w_release;
  logic              w_grant_en;
  logic              w_grant_src;
  logic              w_to_idle;
  logic [DATA_W-1:0] w_dout;

  // In a granted state sel always names the owner, so gnt[sel] & req[sel]
  // is "owner still has data"; in IDLE gnt is 00 and this is 0.
  assign w_valid = r_gnt[r_sel] & bus.req[r_sel];
  assign w_xfer  = w_valid & bus.dout_ready;

  // Owner gave up its request, or this transfer completes the burst.
  assign w_release = (r_state != ST_IDLE) &&
                     (!bus.req[r_sel] ||
                      (w_xfer && (r_cnt == CNT_W'(MAX_BURST - 1))));

  always_comb begin
    w_grant_en  = 1'b0;
    w_grant_src = 1'b0;
    w_to_idle   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (|bus.req) begin
        w_grant_en  = 1'b1;
        w_grant_src = (&bus.req) ? r_pri : bus.req[1];
      end
    end else if (w_release) begin
      // Other source first (no idle bubble), then re-grant of the owner.
      if (bus.req[~r_sel]) begin
        w_grant_en  = 1'b1;
        w_grant_src = ~r_sel;
      end else if (bus.req[r_sel]) begin
        w_grant_en  = 1'b1;
        w_grant_src = r_sel;
      end else begin
        w_to_idle   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_sel   <= 1'b0;
      r_pri   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_grant_en) begin
        r_state <= grant_state(w_grant_src);
        r_gnt   <= grant_vec(w_grant_src);
        r_sel   <= w_grant_src;
      end else if (w_to_idle) begin
        // sel deliberately keeps its last value while idle.
        r_state <= ST_IDLE;
        r_gnt   <= 2'b00;
      end

      if (w_release) begin
        r_pri <= ~r_sel;
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef MUX2_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (w_grant_en) begin
      if (!w_grant_src && (grant_cnt0 != {STAT_W{1'b1}}))
        grant_cnt0 <= grant_cnt0 + 1'b1;
      if (w_grant_src && (grant_cnt1 != {STAT_W{1'b1}}))
        grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

  mux2to1_w #(
    .DATA_W (DATA_W)
  ) u_mux (
    .din0 (bus.din0),
    .din1 (bus.din1),
    .sel  (r_sel),
    .dout (w_dout)
  );

  assign bus.dout       = w_dout;
  assign bus.gnt        = r_gnt;
  assign bus.sel        = r_sel;
  assign bus.dout_valid = w_valid;
  assign bus.rdy        = r_gnt & {2{bus.dout_ready}};

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Purpose  : Self-checking bench for mux2_rr_arbiter (DATA_W=8, MAX_BURST=4).
//            Each source presents {src, sequence} data that advances when it
//            is accepted; expected transfers are queued by the stimulus and
//            popped by an independent monitor.
// Macros   : MUX2_ARB_STATS_EN - also connects and checks grant counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

  localparam int DW = 8;

  logic clk;
  logic rst_n;

  mux2_rr_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] gc0;
  logic [15:0] gc1;
`endif

  mux2_rr_arbiter #(
    .DATA_W    (DW),
    .MAX_BURST (4),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef MUX2_ARB_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];   // {expected sel, expected dout}
  logic [6:0] seq0, seq1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL xfer_unexpected: got sel=%0d dout=%h, expected none",
                 bus.sel, bus.dout);
      end else begin
        chk("xfer", {23'd0, bus.sel, bus.dout}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_data();
    bus.din0 = {1'b0, seq0};
    bus.din1 = {1'b1, seq1};
  endtask

  // One clock; a source advances its data only when it was requesting
  // and was accepted.
  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = bus.rdy[0] & bus.req[0];
    a1 = bus.rdy[1] & bus.req[1];
    @(posedge clk);
    #1;
    if (a0) seq0++;
    if (a1) seq1++;
    drive_data();
  endtask

  task automatic push(input logic src, input logic [7:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req        = 2'b00;
    bus.dout_ready = 1'b0;
    seq0 = '0;
    seq1 = '0;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values, with distinct data so dout-follows-din0 is visible.
    rst_n          = 1'b0;
    bus.req        = 2'b11;
    bus.dout_ready = 1'b1;
    bus.din0       = 8'h5A;
    bus.din1       = 8'hA5;
    #2;
    chk("rst_gnt",   {30'd0, bus.gnt}, 32'd0);
    chk("rst_sel",   {31'd0, bus.sel}, 32'd0);
    chk("rst_rdy",   {30'd0, bus.rdy}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_dout",  {24'd0, bus.dout}, 32'h5A);
    do_reset();

    // Single requester: grant after one edge, burst-limit re-grant w/o gap.
    bus.req = 2'b01;
    bus.dout_ready = 1'b1;
    step();
    chk("t2_gnt",   {30'd0, bus.gnt}, 32'h1);
    chk("t2_valid", {31'd0, bus.dout_valid}, 32'h1);
    chk("t2_dout",  {24'd0, bus.dout}, 32'h00);
    for (int i = 0; i < 6; i++) push(1'b0, 8'(i));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_gnt_hold", {30'd0, bus.gnt}, 32'h1);
    end
    bus.req = 2'b00;
    step();
    chk("t2_idle_gnt", {30'd0, bus.gnt}, 32'h0);

    // Contention from reset: 4 beats each, alternating.
    do_reset();
    bus.req = 2'b11;
    bus.dout_ready = 1'b1;
    step();
    chk("t3_gnt0", {30'd0, bus.gnt}, 32'h1);
    chk("t3_sel0", {31'd0, bus.sel}, 32'h0);
    for (int i = 0; i < 4; i++) push(1'b0, 8'h00 + 8'(i));
    for (int i = 0; i < 4; i++) push(1'b1, 8'h80 + 8'(i));
    for (int i = 0; i < 4; i++) push(1'b0, 8'h04 + 8'(i));
    push(1'b1, 8'h84);
    push(1'b1, 8'h85);
    repeat (4) step();
    chk("t3_gnt1", {30'd0, bus.gnt}, 32'h2);
    chk("t3_sel1", {31'd0, bus.sel}, 32'h1);
    repeat (4) step();
    chk("t3_gnt0b", {30'd0, bus.gnt}, 32'h1);
    chk("t3_sel0b", {31'd0, bus.sel}, 32'h0);
    repeat (4) step();
    chk("t3_gnt1b", {30'd0, bus.gnt}, 32'h2);
`ifdef MUX2_ARB_STATS_EN
    chk("t3_gc0", {16'd0, gc0}, 32'd2);
    chk("t3_gc1", {16'd0, gc1}, 32'd2);
`endif
    repeat (2) step();

    // Asynchronous reset mid-burst, req still 11: outputs drop at once.
    rst_n = 1'b0;
    #1;
    chk("t1_gnt",   {30'd0, bus.gnt}, 32'd0);
    chk("t1_sel",   {31'd0, bus.sel}, 32'd0);
    chk("t1_rdy",   {30'd0, bus.rdy}, 32'd0);
    chk("t1_valid", {31'd0, bus.dout_valid}, 32'd0);
    do_reset();

    // Early release from GNT1 after 2 beats.
    bus.req = 2'b10;
    bus.dout_ready = 1'b1;
    step();
    chk("t4_gnt1", {30'd0, bus.gnt}, 32'h2);
    bus.req = 2'b11;
    push(1'b1, 8'h80);
    push(1'b1, 8'h81);
    repeat (2) step();
    bus.req = 2'b01;
    step();
    chk("t4_gnt0", {30'd0, bus.gnt}, 32'h1);
    chk("t4_sel0", {31'd0, bus.sel}, 32'h0);

    // Backpressure: two beats, 5 stalled cycles, then two more close the burst.
    push(1'b0, 8'h00);
    push(1'b0, 8'h01);
    repeat (2) step();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_gnt_hold", {30'd0, bus.gnt}, 32'h1);
      chk("t5_rdy",      {30'd0, bus.rdy}, 32'h0);
    end
    bus.dout_ready = 1'b1;
    bus.req = 2'b11;
    push(1'b0, 8'h02);
    push(1'b0, 8'h03);
    repeat (2) step();
    chk("t5_gnt1", {30'd0, bus.gnt}, 32'h2);
    chk("t5_sel1", {31'd0, bus.sel}, 32'h1);
    push(1'b1, 8'h82);
    step();
    bus.req = 2'b00;
    step();
    chk("t5_idle_gnt", {30'd0, bus.gnt}, 32'h0);
    chk("t5_idle_sel", {31'd0, bus.sel}, 32'h1);

    repeat (2) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the two-input data mux used in level1.
- Shares one output channel between two requesters.
- Drives the mux select and the per-requester grants.
- Enforces a per-grant burst limit, so neither requester can starve the other.
- Contains the 2:1 datapath mux itself (dout); sel is also exported for external mux instances.

Parameters:
- DATA_W, 1, width of each data input and of dout.
- MAX_BURST, 4, maximum transfers per grant before forced re-arbitration; legal range 1..255.
- CNT_W, 8, width of the burst counter; must satisfy 2**CNT_W > MAX_BURST.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request per source; bit n held high while source n has data.
- din0  in  DATA_W  data from source 0.
- din1  in  DATA_W  data from source 1.
- rdy  out  2  per-source accept; rdy[n] = gnt[n] & dout_ready.
- gnt  out  2  registered one-hot grant, or 00 when idle.
- sel  out  1  registered mux select; 0 selects din0, 1 selects din1.
- dout  out  DATA_W  mux output; sel ? din1 : din0, combinational.
- dout_valid  out  1  gnt[sel] & req[sel].
- dout_ready  in  1  downstream accept.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, gnt=00, sel=0, burst count=0.
  - Round-robin pointer favours source 0 (pri=0).
  - rdy=00, dout_valid=0.
  - dout follows din0.
- Transfer: a transfer occurs on any clock edge where dout_valid & dout_ready.
- State machine: states IDLE, GNT0, GNT1.
- IDLE:
  - req=00: stay in IDLE.
  - One request bit set: grant that source.
  - Both set: grant source pri.
  - Grant latency: gnt and sel update on the edge after req is sampled, i.e. 1 cycle.
- GNTn:
  - Each transfer increments the burst count.
  - Release condition: req[n]=0, or a transfer brings the count to MAX_BURST.
- On release:
  - Set pri = other source (1-n).
  - Clear the burst count.
  - Next state, in order of priority:
    - req[1-n]=1: GNT(1-n) directly, with no idle bubble.
    - Else req[n]=1 (burst limit case): re-grant GNTn with a fresh burst.
    - Else: IDLE.
- sel behaviour:
  - sel changes only on a grant change.
  - sel holds its last value in IDLE.
- Boundary conditions:
  - Simultaneous release and new request from the other source: switch in the same edge.
  - dout_ready low while granted: count is held and the grant is held. No timeout.
  - MAX_BURST=1: grants alternate every transfer whenever both sources request.
  - req[n] dropped mid-burst: release on the next edge. A partial burst does not count against pri beyond the pri swap.
  - rst_n asserted mid-burst: immediate return to reset values. In-flight transfers are abandoned. Upstream sources keep their data because their rdy drops.
- Width rules:
  - Burst count is unsigned CNT_W bits. It never exceeds MAX_BURST, so no wrap.

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counts grant events (entries into GNTn, including re-grants).
  - Counters saturate at 16'hFFFF and are reset to 0 by rst_n.
- Undefined: these ports and counters are absent. The remaining behaviour is identical.

Decomposition:
- Shared package mux2_arb_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2.
  - Default MAX_BURST.
  - Stats counter width STAT_W=16.
- One natural sub-module: mux2to1_w, a DATA_W-wide combinational 2:1 mux producing dout from din0/din1/sel.
- The FSM, pointer and counters stay in the top module.

Test Plan:
1. Reset: assert rst_n=0 mid-run with req=11 -> gnt=00, sel=0, rdy=00, dout_valid=0 immediately, without waiting for a clock edge.
2. Single requester: req=01, dout_ready=1, din0=1 -> gnt=01 one cycle later, dout=1, dout_valid=1. After 4 transfers, count resets and GNT0 is re-granted with no gap.
3. Contention: req=11 from reset, dout_ready=1, MAX_BURST=4 -> 4 transfers from src0, then gnt=10 and sel=1 on the following edge. Then 4 from src1, then back to src0.
4. Early release: GNT1 with req=11, drop req[1] after 2 transfers -> next edge gnt=01, sel=0, pri=0.
5. Backpressure: GNT0, dout_ready=0 for 5 cycles -> gnt stays 01, rdy=00, count unchanged. Release dout_ready -> transfers resume.
6. MUX2_ARB_STATS_EN defined, test 3 run for 3 full rotations -> grant_cnt0=3, grant_cnt1=3. Force 70000 grants -> grant_cnt0 holds at 16'hFFFF.
